// File: rtl/sudoku_pkg.sv
// sudoku_pkg: state codes shared with the state-to-enable decoder, plus grid defaults.
package sudoku_pkg;
   localparam logic [2:0] RECEBE_LINHA  = 3'b000;
   localparam logic [2:0] RECEBE_COLUNA = 3'b001;
   localparam logic [2:0] VERIFICA_POS  = 3'b010;
   localparam logic [2:0] RECEBE_VALOR  = 3'b011;
   localparam logic [2:0] VERIFICA_JOGO = 3'b100;
   localparam logic [2:0] FIM_JOGO      = 3'b101;
   localparam int N_DEF = 9;
   localparam int W_DEF = 4;
endpackage

// File: rtl/sudoku_game_fsm_if.sv
// sudoku_game_fsm_if: user entry, checker results and controller outputs of the game FSM.
interface sudoku_game_fsm_if import sudoku_pkg::*; #(parameter int W = W_DEF);
   logic         confirma;
   logic [W-1:0] entrada;
   logic         pos_valid;
   logic         pos_ok;
   logic         jogo_valid;
   logic         jogo_completo;
   logic [2:0]   estado_jogo;
   logic [W-1:0] linha;
   logic [W-1:0] coluna;
   logic [W-1:0] valor;
   logic         escreve;
   logic         erro_entrada;
   logic [7:0]   jogadas;
   logic [3:0]   erros;
   logic         perdeu;
   modport master (
      input  confirma, entrada, pos_valid, pos_ok, jogo_valid, jogo_completo,
      output estado_jogo, linha, coluna, valor, escreve, erro_entrada, jogadas, erros, perdeu
   );
   modport slave (
      output confirma, entrada, pos_valid, pos_ok, jogo_valid, jogo_completo,
      input  estado_jogo, linha, coluna, valor, escreve, erro_entrada, jogadas, erros, perdeu
   );
endinterface

// File: rtl/sudoku_sat_counter.sv
// sudoku_sat_counter: up-counter with enable and clear that sticks at its maximum value.
module sudoku_sat_counter #(parameter int WIDTH = 8) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk)
      if (rst || clr) q <= '0;
      else if (en && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/sudoku_game_fsm.sv
// sudoku_game_fsm: Sudoku move sequencer; define SUDOKU_ERROR_LIMIT_EN to end the game after MAX_ERROS rejections.
module sudoku_game_fsm import sudoku_pkg::*; #(
   parameter int N = N_DEF,
   parameter int W = W_DEF
`ifdef SUDOKU_ERROR_LIMIT_EN
   , parameter int MAX_ERROS = 3
`endif
) (
   input logic clk,
   input logic reset,
   sudoku_game_fsm_if.master bus
);
   localparam logic [W-1:0] NMAX = W'(N);
   logic [2:0]   estado, prox;
   logic [W-1:0] linha, coluna, valor;
   logic         escreve, erro_entrada, perdeu, ok, entra, acc, rej, nova, lim;
   logic [7:0]   jogadas;
   logic [3:0]   erros;
   assign ok    = bus.entrada != '0 && bus.entrada <= NMAX;
   assign entra = bus.confirma && (estado == RECEBE_LINHA || estado == RECEBE_COLUNA || estado == RECEBE_VALOR);
   assign acc   = estado == RECEBE_VALOR && bus.confirma && ok;
   assign rej   = estado == VERIFICA_POS && bus.pos_valid && !bus.pos_ok;
   assign nova  = estado == FIM_JOGO && bus.confirma;
`ifdef SUDOKU_ERROR_LIMIT_EN
   localparam logic [3:0] ELIM = 4'(MAX_ERROS - 1);
   // The rejection being counted now is the one that reaches the limit.
   assign lim = erros == ELIM;
   always_ff @(posedge clk)
      if (reset || nova) perdeu <= 1'b0;
      else if (rej && lim) perdeu <= 1'b1;
`else
   assign lim    = 1'b0;
   assign perdeu = 1'b0;
`endif
   always_comb begin
      prox = RECEBE_LINHA;
      case (estado)
         RECEBE_LINHA:  prox = bus.confirma && ok ? RECEBE_COLUNA : RECEBE_LINHA;
         RECEBE_COLUNA: prox = bus.confirma && ok ? VERIFICA_POS : RECEBE_COLUNA;
         VERIFICA_POS:  prox = !bus.pos_valid ? VERIFICA_POS : bus.pos_ok ? RECEBE_VALOR : lim ? FIM_JOGO : RECEBE_LINHA;
         RECEBE_VALOR:  prox = acc ? VERIFICA_JOGO : RECEBE_VALOR;
         VERIFICA_JOGO: prox = !bus.jogo_valid ? VERIFICA_JOGO : bus.jogo_completo ? FIM_JOGO : RECEBE_LINHA;
         FIM_JOGO:      prox = bus.confirma ? RECEBE_LINHA : FIM_JOGO;
         default:       prox = RECEBE_LINHA;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset || nova) begin
         linha  <= '0;
         coluna <= '0;
         valor  <= '0;
      end else if (bus.confirma && ok) begin
         if (estado == RECEBE_LINHA) linha <= bus.entrada;
         if (estado == RECEBE_COLUNA) coluna <= bus.entrada;
         if (estado == RECEBE_VALOR) valor <= bus.entrada;
      end
      if (reset) begin
         estado       <= RECEBE_LINHA;
         escreve      <= 1'b0;
         erro_entrada <= 1'b0;
      end else begin
         estado       <= prox;
         escreve      <= acc;
         erro_entrada <= entra && !ok;
      end
   end
   sudoku_sat_counter #(.WIDTH(8)) u_jogadas (.clk(clk), .rst(reset), .clr(nova), .en(acc), .q(jogadas));
   sudoku_sat_counter #(.WIDTH(4)) u_erros (.clk(clk), .rst(reset), .clr(nova), .en(rej), .q(erros));
   assign bus.estado_jogo  = estado;
   assign bus.linha        = linha;
   assign bus.coluna       = coluna;
   assign bus.valor        = valor;
   assign bus.escreve      = escreve;
   assign bus.erro_entrada = erro_entrada;
   assign bus.jogadas      = jogadas;
   assign bus.erros        = erros;
   assign bus.perdeu       = perdeu;
endmodule

// File: tb/tb_sudoku_game_fsm.sv
// tb_sudoku_game_fsm: directed checks of the game FSM; follows SUDOKU_ERROR_LIMIT_EN when defined.
module tb_sudoku_game_fsm;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int passed = 0;
   int total = 0;
   sudoku_game_fsm_if #(.W(4)) bus ();
   sudoku_game_fsm dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // Inputs are applied on a falling edge and held across one rising edge; outputs are read on the next falling edge.
   task automatic step(input logic c, input logic [3:0] e, input logic pv, input logic pk, input logic jv, input logic jc);
      bus.confirma = c;
      bus.entrada = e;
      bus.pos_valid = pv;
      bus.pos_ok = pk;
      bus.jogo_valid = jv;
      bus.jogo_completo = jc;
      @(negedge clk);
      bus.confirma = 1'b0;
      bus.pos_valid = 1'b0;
      bus.jogo_valid = 1'b0;
   endtask
   task automatic test_reset;
      reset = 1'b1;
      step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      total++; if (bus.estado_jogo !== 3'b000) $display("FAIL reset_estado: got %b expected 000", bus.estado_jogo); else passed++;
      total++; if (bus.linha !== 4'd0 || bus.coluna !== 4'd0 || bus.valor !== 4'd0) $display("FAIL reset_regs: got %0d/%0d/%0d expected 0/0/0", bus.linha, bus.coluna, bus.valor); else passed++;
      total++; if (bus.jogadas !== 8'd0 || bus.erros !== 4'd0 || bus.perdeu !== 1'b0) $display("FAIL reset_stats: got %0d/%0d/%b expected 0/0/0", bus.jogadas, bus.erros, bus.perdeu); else passed++;
      total++; if (bus.escreve !== 1'b0 || bus.erro_entrada !== 1'b0) $display("FAIL reset_pulses: got %b/%b expected 0/0", bus.escreve, bus.erro_entrada); else passed++;
   endtask
   task automatic test_move;
      step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.estado_jogo !== 3'b001 || bus.linha !== 4'd3) $display("FAIL move_linha: got %b/%0d expected 001/3", bus.estado_jogo, bus.linha); else passed++;
      step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.estado_jogo !== 3'b010 || bus.coluna !== 4'd5) $display("FAIL move_coluna: got %b/%0d expected 010/5", bus.estado_jogo, bus.coluna); else passed++;
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      total++; if (bus.estado_jogo !== 3'b011) $display("FAIL move_pos_ok: got %b expected 011", bus.estado_jogo); else passed++;
      step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.estado_jogo !== 3'b100 || bus.valor !== 4'd7) $display("FAIL move_valor: got %b/%0d expected 100/7", bus.estado_jogo, bus.valor); else passed++;
      total++; if (bus.escreve !== 1'b1 || bus.jogadas !== 8'd1) $display("FAIL move_escreve: got %b/%0d expected 1/1", bus.escreve, bus.jogadas); else passed++;
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.escreve !== 1'b0 || bus.estado_jogo !== 3'b100) $display("FAIL move_escreve_once: got %b/%b expected 0/100", bus.escreve, bus.estado_jogo); else passed++;
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (bus.estado_jogo !== 3'b000 || bus.linha !== 4'd3 || bus.valor !== 4'd7) $display("FAIL move_jogo_incompleto: got %b/%0d/%0d expected 000/3/7", bus.estado_jogo, bus.linha, bus.valor); else passed++;
   endtask
   task automatic test_range;
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.erro_entrada !== 1'b1 || bus.estado_jogo !== 3'b000 || bus.linha !== 4'd3) $display("FAIL range_zero: got %b/%b/%0d expected 1/000/3", bus.erro_entrada, bus.estado_jogo, bus.linha); else passed++;
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.erro_entrada !== 1'b0) $display("FAIL range_pulse_end: got %b expected 0", bus.erro_entrada); else passed++;
      step(1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.erro_entrada !== 1'b1 || bus.estado_jogo !== 3'b000 || bus.linha !== 4'd3) $display("FAIL range_ten: got %b/%b/%0d expected 1/000/3", bus.erro_entrada, bus.estado_jogo, bus.linha); else passed++;
   endtask
   task automatic test_reject;
      step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.estado_jogo !== 3'b010 || bus.linha !== 4'd1 || bus.coluna !== 4'd9) $display("FAIL reject_entry: got %b/%0d/%0d expected 010/1/9", bus.estado_jogo, bus.linha, bus.coluna); else passed++;
      step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.estado_jogo !== 3'b010 || bus.coluna !== 4'd9) $display("FAIL reject_confirma_ignored: got %b/%0d expected 010/9", bus.estado_jogo, bus.coluna); else passed++;
      step(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      total++; if (bus.estado_jogo !== 3'b000 || bus.erros !== 4'd1 || bus.linha !== 4'd1 || bus.coluna !== 4'd9) $display("FAIL reject_first: got %b/%0d/%0d/%0d expected 000/1/1/9", bus.estado_jogo, bus.erros, bus.linha, bus.coluna); else passed++;
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.estado_jogo !== 3'b000 || bus.erro_entrada !== 1'b0) $display("FAIL reject_confirma_dropped: got %b/%b expected 000/0", bus.estado_jogo, bus.erro_entrada); else passed++;
   endtask
   task automatic test_error_limit;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      total++; if (bus.erros !== 4'd3) $display("FAIL limit_erros: got %0d expected 3", bus.erros); else passed++;
`ifdef SUDOKU_ERROR_LIMIT_EN
      total++; if (bus.estado_jogo !== 3'b101 || bus.perdeu !== 1'b1) $display("FAIL limit_perdeu: got %b/%b expected 101/1", bus.estado_jogo, bus.perdeu); else passed++;
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.estado_jogo !== 3'b000 || bus.perdeu !== 1'b0 || bus.erros !== 4'd0) $display("FAIL limit_new_game: got %b/%b/%0d expected 000/0/0", bus.estado_jogo, bus.perdeu, bus.erros); else passed++;
`else
      total++; if (bus.estado_jogo !== 3'b000 || bus.perdeu !== 1'b0) $display("FAIL limit_none: got %b/%b expected 000/0", bus.estado_jogo, bus.perdeu); else passed++;
`endif
   endtask
   task automatic test_win;
      logic [7:0] exp_jog;
`ifdef SUDOKU_ERROR_LIMIT_EN
      exp_jog = 8'd1;
`else
      exp_jog = 8'd2;
`endif
      step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.estado_jogo !== 3'b100 || bus.valor !== 4'd9 || bus.jogadas !== exp_jog) $display("FAIL win_valor: got %b/%0d/%0d expected 100/9/%0d", bus.estado_jogo, bus.valor, bus.jogadas, exp_jog); else passed++;
      step(1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
      total++; if (bus.estado_jogo !== 3'b101 || bus.linha !== 4'd2 || bus.coluna !== 4'd3) $display("FAIL win_fim: got %b/%0d/%0d expected 101/2/3", bus.estado_jogo, bus.linha, bus.coluna); else passed++;
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      total++; if (bus.estado_jogo !== 3'b101 || bus.valor !== 4'd9 || bus.jogadas !== exp_jog) $display("FAIL win_hold: got %b/%0d/%0d expected 101/9/%0d", bus.estado_jogo, bus.valor, bus.jogadas, exp_jog); else passed++;
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.estado_jogo !== 3'b000 || bus.jogadas !== 8'd0 || bus.erros !== 4'd0 || bus.perdeu !== 1'b0) $display("FAIL win_new_game_stats: got %b/%0d/%0d/%b expected 000/0/0/0", bus.estado_jogo, bus.jogadas, bus.erros, bus.perdeu); else passed++;
      total++; if (bus.linha !== 4'd0 || bus.coluna !== 4'd0 || bus.valor !== 4'd0 || bus.erro_entrada !== 1'b0) $display("FAIL win_new_game_regs: got %0d/%0d/%0d/%b expected 0/0/0/0", bus.linha, bus.coluna, bus.valor, bus.erro_entrada); else passed++;
   endtask
   task automatic test_reset_mid;
      step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      total++; if (bus.estado_jogo !== 3'b011 || bus.linha !== 4'd4 || bus.coluna !== 4'd6) $display("FAIL mid_setup: got %b/%0d/%0d expected 011/4/6", bus.estado_jogo, bus.linha, bus.coluna); else passed++;
      reset = 1'b1;
      step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      total++; if (bus.estado_jogo !== 3'b000 || bus.linha !== 4'd0 || bus.coluna !== 4'd0 || bus.valor !== 4'd0) $display("FAIL mid_reset_regs: got %b/%0d/%0d/%0d expected 000/0/0/0", bus.estado_jogo, bus.linha, bus.coluna, bus.valor); else passed++;
      total++; if (bus.escreve !== 1'b0 || bus.jogadas !== 8'd0 || bus.erros !== 4'd0 || bus.perdeu !== 1'b0) $display("FAIL mid_reset_stats: got %b/%0d/%0d/%b expected 0/0/0/0", bus.escreve, bus.jogadas, bus.erros, bus.perdeu); else passed++;
   endtask
   initial begin
      bus.confirma = 1'b0;
      bus.entrada = 4'd0;
      bus.pos_valid = 1'b0;
      bus.pos_ok = 1'b0;
      bus.jogo_valid = 1'b0;
      bus.jogo_completo = 1'b0;
      @(negedge clk);
      test_reset;
      test_move;
      test_range;
      test_reject;
      test_error_limit;
      test_win;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
